// File: rtl/led_pwm_pkg.sv
// Shared constants and encodings for the multi-channel LED PWM block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_pwm_pkg;

  localparam int DEF_WIDTH    = 17;
  localparam int DEF_CHANNELS = 4;

  // Counting scheme selected by the mode input
  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  // Direction of the shared counter in center-aligned operation
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM counter: edge (0..P-1 wrap) or center (0..P-1, P-1..0) counting with boundary flag.
// Latency: o_cnt is registered; o_bnd is combinational from the current count.
// Backpressure: none; free-running while i_run is high, parked at 0 / up otherwise.
module pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  pwm_mode_e        i_mode,
  input  logic [WIDTH-1:0] i_period,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_bnd
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_last;
  pwm_dir_e         r_dir;
  pwm_dir_e         w_dir_nxt;

  // i_run guarantees i_period is non-zero, so this never underflows when used
  assign w_last = i_period - WIDTH'(1);
  assign o_cnt  = r_cnt;

  // Next count/direction and the last-cycle-of-period flag
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    o_bnd     = 1'b0;
    if (!i_run) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else if (i_mode == MODE_EDGE) begin
      w_dir_nxt = DIR_UP;
      if (r_cnt >= w_last) begin
        o_bnd     = 1'b1;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + WIDTH'(1);
      end
    end else if (r_dir == DIR_UP) begin
      // top endpoint is held for a second cycle while turning around
      if (r_cnt >= w_last) begin
        w_dir_nxt = DIR_DOWN;
      end else begin
        w_cnt_nxt = r_cnt + WIDTH'(1);
      end
    end else begin
      // bottom endpoint: this is the last cycle; the next period re-starts at 0
      if (r_cnt == '0) begin
        o_bnd     = 1'b1;
        w_dir_nxt = DIR_UP;
      end else begin
        w_cnt_nxt = r_cnt - WIDTH'(1);
      end
    end
  end

  // Counter and direction state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
    end
  end

endmodule

// File: rtl/led_pwm_multi.sv
// Multi-channel LED PWM: shared timebase, per-channel pending/shadow duty, glitch-free updates.
// Latency: pwm and period_tick are registered, one cycle behind the counter value they reflect.
// Backpressure: none; duty writes are accepted every cycle and applied at the period boundary.
module led_pwm_multi
  import led_pwm_pkg::*;
#(
  parameter int                  CHANNELS = DEF_CHANNELS,
  parameter int                  WIDTH    = DEF_WIDTH,
  parameter logic [CHANNELS-1:0] INVERT   = '0,
  localparam int                 CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [WIDTH-1:0]    freq,
  input  logic                wr_en,
  input  logic [CHW-1:0]      wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_tick
);

  logic [WIDTH-1:0]    r_pend    [CHANNELS];
  logic [WIDTH-1:0]    r_duty_sh [CHANNELS];
  logic [WIDTH-1:0]    r_p_sh;
  pwm_mode_e           r_mode_sh;
  logic [CHANNELS-1:0] r_pwm;
  logic                r_bnd_d;
  logic                r_tick;

  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_cmp;
  logic [WIDTH-1:0]    w_cnt;
  logic                w_bnd;
  logic                w_run;
  logic                w_load;

  // A zero shadow period parks the block exactly like en low does
  assign w_run  = en && (r_p_sh != '0);
  // Shadows track the inputs while parked, and latch once per period while running
  assign w_load = !w_run || w_bnd;

  assign pwm         = r_pwm;
  assign period_tick = r_tick;

  pwm_timebase #(
    .WIDTH (WIDTH)
  ) u_timebase (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_run    (w_run),
    .i_mode   (r_mode_sh),
    .i_period (r_p_sh),
    .o_cnt    (w_cnt),
    .o_bnd    (w_bnd)
  );

  // Per-channel write decode; indices beyond CHANNELS match no channel and are dropped
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_hit[i] = wr_en && (wr_ch == CHW'(i));
    end
  end

  // Pending duty registers, updated on any valid write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_hit[i]) begin
          r_pend[i] <= wr_duty;
        end
      end
    end
  end

  // Shadow registers; a write landing on the load cycle bypasses the pending copy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_sh    <= '0;
      r_mode_sh <= MODE_EDGE;
      for (int i = 0; i < CHANNELS; i++) begin
        r_duty_sh[i] <= '0;
      end
    end else if (w_load) begin
      r_p_sh    <= freq;
      r_mode_sh <= pwm_mode_e'(mode);
      for (int i = 0; i < CHANNELS; i++) begin
        r_duty_sh[i] <= w_hit[i] ? wr_duty : r_pend[i];
      end
    end
  end

  // Full-width unsigned duty comparators against the shared count
  always_comb begin
    w_cmp = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cmp[i] = (w_cnt < r_duty_sh[i]);
    end
  end

  // Output stage; tick is delayed twice so it lines up with the cnt==0 output sample
  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_pwm   <= INVERT;
      r_bnd_d <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_pwm   <= w_cmp ^ INVERT;
      r_bnd_d <= w_bnd;
      r_tick  <= r_bnd_d;
    end
  end

endmodule

// File: tb/tb_led_pwm_multi.sv
// Self-checking bench for led_pwm_multi: directed scenarios then randomized traffic vs a position model.
// Latency: checks outputs at the falling edge, after the rising edge that produced them.
// Backpressure: n/a.
module tb_led_pwm_multi;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic [16:0] freq;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [16:0] wr_duty;
  logic [3:0]  pwm;
  logic        tick;
  logic [3:0]  pwm_inv;
  logic        tick_inv;

  int total = 0;
  int bad   = 0;

  // capture shift registers: oldest sample ends up in the highest used bit
  logic [63:0] c0, c1, c2, c3, ct, ci;

  // reference model state: position inside the period plus shadow/pending copies
  int         m_pos;
  int         m_sp;
  logic       m_smode;
  logic       m_wrap;
  int         m_pend  [4];
  int         m_sduty [4];
  logic [3:0] m_pwm;
  logic       m_tick;

  led_pwm_multi #(
    .CHANNELS (4),
    .WIDTH    (17),
    .INVERT   (4'b0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .freq        (freq),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .pwm         (pwm),
    .period_tick (tick)
  );

  led_pwm_multi #(
    .CHANNELS (4),
    .WIDTH    (17),
    .INVERT   (4'b0101)
  ) dut_inv (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .freq        (freq),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .pwm         (pwm_inv),
    .period_tick (tick_inv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_duty(input logic [1:0] ch, input logic [16:0] d);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_duty = d;
    @(negedge clk);
    wr_en = 1'b0;
    chk("idle_pwm", {28'd0, pwm}, 32'd0);
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, tick}, 32'd1);
  endtask

  // Records n output samples starting with the current one; optional ch0 write at sample wr_at
  task automatic capture(input int n, input int wr_at, input logic [16:0] wr_val);
    c0 = '0; c1 = '0; c2 = '0; c3 = '0; ct = '0; ci = '0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      c0 = {c0[62:0], pwm[0]};
      c1 = {c1[62:0], pwm[1]};
      c2 = {c2[62:0], pwm[2]};
      c3 = {c3[62:0], pwm[3]};
      ct = {ct[62:0], tick};
      ci = {ci[62:0], pwm_inv[0]};
      if (k == wr_at) begin
        wr_en   = 1'b1;
        wr_ch   = 2'd0;
        wr_duty = wr_val;
      end else begin
        wr_en = 1'b0;
      end
    end
  endtask

  // One clock of the model, using the inputs about to be sampled; sets outputs seen after the edge
  task automatic model_step();
    int   plen;
    int   cv;
    logic run;
    logic bnd;
    if (rst) begin
      m_pos = 0; m_sp = 0; m_smode = 1'b0; m_wrap = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_pend[i]  = 0;
        m_sduty[i] = 0;
      end
      m_pwm  = 4'b0000;
      m_tick = 1'b0;
      return;
    end
    run  = en && (m_sp != 0);
    plen = m_smode ? 2 * m_sp : m_sp;
    cv   = (m_pos < m_sp) ? m_pos : (plen - 1 - m_pos);
    bnd  = run && (m_pos == plen - 1);
    if (run) begin
      for (int i = 0; i < 4; i++) m_pwm[i] = (cv < m_sduty[i]);
      m_tick = m_wrap;
    end else begin
      m_pwm  = 4'b0000;
      m_tick = 1'b0;
    end
    m_wrap = bnd;
    if (wr_en) m_pend[wr_ch] = int'(wr_duty);
    if (!run || bnd) begin
      m_sp    = int'(freq);
      m_smode = mode;
      for (int i = 0; i < 4; i++) m_sduty[i] = m_pend[i];
      m_pos = 0;
    end else begin
      m_pos = m_pos + 1;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; freq = '0;
    wr_en = 1'b0; wr_ch = '0; wr_duty = '0;

    // reset held for three cycles, outputs at idle level
    repeat (3) begin
      @(negedge clk);
      chk("rst_pwm", {28'd0, pwm}, 32'd0);
      chk("rst_tick", {31'd0, tick}, 32'd0);
      chk("rst_pwm_inv", {28'd0, pwm_inv}, 32'h5);
    end
    rst = 1'b0;

    // duties loaded while disabled
    write_duty(2'd0, 17'd3);
    write_duty(2'd1, 17'd0);
    write_duty(2'd2, 17'd10);
    write_duty(2'd3, 17'd15);
    chk("idle_tick", {31'd0, tick}, 32'd0);

    // edge mode, period 10
    freq = 17'd10; mode = 1'b0; en = 1'b1;
    @(negedge clk);
    wait_tick("edge_first_tick");
    capture(30, -1, 17'd0);
    chk("edge_pwm0", {2'd0, c0[29:0]}, {2'd0, {3{10'b1110000000}}});
    chk("edge_tick", {2'd0, ct[29:0]}, {2'd0, {3{10'b1000000000}}});
    chk("duty0_ch1", {2'd0, c1[29:0]}, 32'h0);
    chk("duty_eq_p_ch2", {2'd0, c2[29:0]}, 32'h3FFF_FFFF);
    chk("duty_gt_p_ch3", {2'd0, c3[29:0]}, 32'h3FFF_FFFF);
    chk("edge_inv_ch0", {2'd0, ci[29:0]}, {2'd0, {3{10'b0001111111}}});

    // ch0 rewritten to 7 while cnt = 5: this period stays 3, next is 7
    wait_tick("rewrite_tick");
    capture(20, 4, 17'd7);
    chk("rewrite_pwm0", {12'd0, c0[19:0]}, {12'd0, 10'b1110000000, 10'b1111111000});
    chk("rewrite_tick_pat", {12'd0, ct[19:0]}, {12'd0, 10'b1000000000, 10'b1000000000});

    // center mode, half-period 8, duty 2
    wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 17'd2;
    mode = 1'b1; freq = 17'd8;
    @(negedge clk);
    wr_en = 1'b0;
    wait_tick("center_tick");
    capture(32, -1, 17'd0);
    chk("center_pwm0", c0[31:0], {2{16'b1100000000000011}});
    chk("center_tick_pat", ct[31:0], {2{16'b1000000000000000}});

    // one-cycle reset in the middle of a period
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_pwm", {28'd0, pwm}, 32'd0);
    chk("midrst_tick", {31'd0, tick}, 32'd0);
    chk("midrst_pwm_inv", {28'd0, pwm_inv}, 32'h5);
    capture(12, -1, 17'd0);
    chk("post_rst_low", {20'd0, c0[11:0] | c1[11:0] | c2[11:0] | c3[11:0]}, 32'd0);

    // ch0 rewrite then enable: counting restarts at 0
    en = 1'b0; mode = 1'b0; freq = 17'd10;
    @(negedge clk);
    write_duty(2'd0, 17'd3);
    en = 1'b1;
    @(negedge clk);
    capture(11, -1, 17'd0);
    chk("restart_pwm0", {21'd0, c0[10:0]}, {21'd0, 11'b11100000001});
    chk("restart_tick", {21'd0, ct[10:0]}, {21'd0, 11'b00000000001});

    // randomized traffic against the model
    rst = 1'b1; en = 1'b0; wr_en = 1'b0;
    model_step();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      chk("rnd_pwm", {28'd0, pwm}, {28'd0, m_pwm});
      chk("rnd_tick", {31'd0, tick}, {31'd0, m_tick});
      chk("rnd_pwm_inv", {28'd0, pwm_inv}, {28'd0, m_pwm ^ 4'b0101});
      chk("rnd_tick_inv", {31'd0, tick_inv}, {31'd0, m_tick});
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) begin
        freq = 17'($urandom_range(0, 12));
        mode = 1'($urandom_range(0, 1));
      end
      if (en) en = ($urandom_range(0, 49) != 0);
      else    en = ($urandom_range(0, 3) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_duty = ($urandom_range(0, 9) == 0) ? 17'h1FFFF : 17'($urandom_range(0, 14));
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pwm_multi.md
LED_PWM_MULTI -- requirements
Module: led_pwm_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent PWM outputs (1..16).
REQ-002 SHALL have parameter WIDTH, default 17: width of the counter, period and duty values.
REQ-003 SHALL have parameter INVERT, default 0: CHANNELS-bit mask; a set bit inverts that channel's output, including its idle level.
REQ-004 SHALL have port clk  input  1: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port en  input  1: run enable; when low, the counter holds and the outputs sit at idle level.
REQ-007 SHALL have port mode  input  1: 0 selects edge-aligned operation; 1 selects center-aligned operation.
REQ-008 SHALL have port freq  input  WIDTH: period value P in clk cycles (edge mode) or half-period (center mode).
REQ-009 SHALL have port wr_en  input  1: one-cycle duty write strobe.
REQ-010 SHALL have port wr_ch  input  clog2(CHANNELS), minimum 1 bit: channel index for the duty write.
REQ-011 SHALL have port wr_duty  input  WIDTH: duty value to write.
REQ-012 SHALL have port pwm  output  CHANNELS: registered PWM outputs.
REQ-013 SHALL have port period_tick  output  1: registered one-cycle pulse at each period start.

Function
REQ-014 SHALL keep one shared counter cnt (WIDTH bits), a direction flag, a pending duty register per channel, and shadow registers for duty[ch], P and mode.
REQ-015 SHALL, on wr_en with wr_ch < CHANNELS, write wr_duty into the pending duty register of wr_ch; writes with wr_ch >= CHANNELS SHALL be ignored.
REQ-016 SHALL, in edge mode, count cnt 0,1,...,P-1 and then wrap to 0, giving a period of P cycles.
REQ-017 SHALL, in center mode, count cnt up 0..P-1 and then down P-1..0, holding each endpoint value for two cycles, giving a period of 2P cycles.
REQ-018 SHALL define the boundary cycle as cnt==P-1 in edge mode, or cnt==0 while counting down in center mode.
REQ-019 SHALL, in the boundary cycle, copy all pending duties, freq and mode into the shadow registers and reset the direction flag to up.
REQ-020 SHALL, when a write coincides with the boundary cycle, load the new wr_duty into the shadow register directly.
REQ-021 SHALL ignore changes to freq and mode mid-period; they take effect only at the next boundary.
REQ-022 SHALL compute pwm[i] <= (cnt < duty_sh[i]) XOR INVERT[i], with a one-cycle latency from cnt.
REQ-023 SHALL, when duty_sh[i] = 0, hold pwm[i] constantly at its idle level.
REQ-024 SHALL, when duty_sh[i] >= P, hold pwm[i] constantly active.
REQ-025 SHALL pulse period_tick high for the one cycle after the boundary, aligned with the first output sample of the new period.
REQ-026 SHALL, when shadow P = 0, hold cnt at 0, hold the outputs idle, suppress period_tick, and load the shadow registers every cycle.
REQ-027 SHALL, when P = 1 in edge mode, assert period_tick every cycle.
REQ-028 SHALL, while en = 0, hold cnt = 0 and direction up, drive pwm = INVERT and period_tick = 0, and load the shadow registers every cycle, so the first enabled period uses the latest values.
REQ-029 SHALL perform all comparisons unsigned, with full WIDTH bits and no truncation.

Reset
REQ-030 SHALL, with rst high at a clock edge, set cnt = 0, direction up, all pending and shadow duties = 0, shadow P = 0, shadow mode = 0, pwm = INVERT, and period_tick = 0.
REQ-031 SHALL let rst take priority over en and wr_en.
REQ-032 SHALL, when rst is asserted mid-period, abort the period; counting restarts from 0 after the first boundary that follows reset.

Structure
REQ-033 SHALL place the mode encodings (MODE_EDGE = 0, MODE_CENTER = 1) and the default WIDTH/CHANNELS constants in the shared package led_pwm_pkg.
REQ-034 SHALL implement the counter, direction flag and boundary detect in the sub-module pwm_timebase; led_pwm_multi instantiates it once and holds the registers and comparators.

Verification (CHANNELS = 4, WIDTH = 17, INVERT = 0 unless stated)
REQ-035 SHALL cover: rst held 3 cycles, en = 0 -> pwm = 0000 and period_tick = 0 throughout; with INVERT = 4'b0101, pwm = 0101.
REQ-036 SHALL cover: edge mode, freq = 10, duty ch0 = 3, en = 1 -> pwm[0] high exactly 3 of every 10 cycles, and period_tick every 10 cycles.
REQ-037 SHALL cover: duties ch1 = 0, ch2 = 10, ch3 = 15 with freq = 10 -> pwm[1] constantly 0; pwm[2] and pwm[3] constantly 1.
REQ-038 SHALL cover: a write of ch0 = 7 at cnt = 5 -> the current period still shows 3 high cycles, and the next period shows 7, with no short pulse between them.
REQ-039 SHALL cover: center mode, freq = 8, duty ch0 = 2 -> period 16, pwm[0] high 4 consecutive cycles around the valley, and period_tick every 16 cycles.
REQ-040 SHALL cover: rst pulsed for one cycle mid-period -> the next cycle shows pwm = 0000 and period_tick = 0, duties read back 0 (outputs stay low until rewritten), and a ch0 write followed by en restarts counting at 0.
